// File: rtl/voice_scheduler.sv
// Three-voice note scheduler: places note requests on free voices and counts
// their durations down on beats. Define VOICE_STEAL_EN to steal a busy voice instead of dropping.
module voice_scheduler #(
  parameter int DUR_W  = 6,
  parameter int NOTE_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic              beat,
  input  logic              load_new_note,
  input  logic [NOTE_W-1:0] note_in,
  input  logic [DUR_W-1:0]  duration_in,
  input  logic              activate,
  output logic [2:0]        voice_load,
  output logic [NOTE_W-1:0] voice_note,
  output logic [DUR_W-1:0]  voice_duration,
  output logic [2:0]        voice_active,
  output logic              activate_done,
  output logic              note_done,
  output logic              dropped
);

  // state   | meaning
  // S_IDLE  | no chord in progress, beats ignored
  // S_LOAD  | chord being assembled, beats ignored
  // S_COUNT | durations counting down on beats while play is high
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_COUNT = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [DUR_W-1:0] cnt     [3];
  logic [DUR_W-1:0] cnt_nxt [3];
  logic             dec, req, drop_nxt, ndone_nxt, all_zero;
  logic [2:0]       free, pick, load_sel;

  always_comb begin
    dec = (state == S_COUNT) && play && beat;
    req = load_new_note && (duration_in != '0);

    // a voice expiring on this very beat is already free for a new note
    for (int i = 0; i < 3; i++)
      free[i] = (cnt[i] == '0) || (dec && (cnt[i] == DUR_W'(1)));

    pick = 3'b000;
    if (free[0])      pick = 3'b001;
    else if (free[1]) pick = 3'b010;
    else if (free[2]) pick = 3'b100;
    else begin
`ifdef VOICE_STEAL_EN
      if ((cnt[0] <= cnt[1]) && (cnt[0] <= cnt[2])) pick = 3'b001;
      else if (cnt[1] <= cnt[2])                    pick = 3'b010;
      else                                          pick = 3'b100;
`endif
    end

    load_sel = req ? pick : 3'b000;
`ifdef VOICE_STEAL_EN
    drop_nxt = 1'b0;
`else
    drop_nxt = req && (free == 3'b000);
`endif

    for (int i = 0; i < 3; i++) begin
      if (load_sel[i])                cnt_nxt[i] = duration_in;
      else if (dec && cnt[i] != '0)   cnt_nxt[i] = cnt[i] - DUR_W'(1);
      else                            cnt_nxt[i] = cnt[i];
    end
    all_zero = (cnt_nxt[0] == '0) && (cnt_nxt[1] == '0) && (cnt_nxt[2] == '0);

    state_nxt = state;
    ndone_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        if (activate) begin
          if (all_zero) ndone_nxt = 1'b1;
          else          state_nxt = S_COUNT;
        end else if (load_sel != 3'b000) begin
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: if (activate) state_nxt = S_COUNT;
      S_COUNT: begin
        if (all_zero) begin
          state_nxt = S_IDLE;
          ndone_nxt = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
      voice_load     <= 3'b000;
      voice_note     <= '0;
      voice_duration <= '0;
      activate_done  <= 1'b0;
      note_done      <= 1'b0;
      dropped        <= 1'b0;
    end else begin
      state          <= state_nxt;
      for (int i = 0; i < 3; i++) cnt[i] <= cnt_nxt[i];
      voice_load     <= load_sel;
      voice_note     <= (load_sel != 3'b000) ? note_in : '0;
      voice_duration <= (load_sel != 3'b000) ? duration_in : '0;
      activate_done  <= activate;
      note_done      <= ndone_nxt;
      dropped        <= drop_nxt;
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) voice_active[i] = (cnt[i] != '0);
  end

endmodule

// File: doc/voice_scheduler.md
VOICE_SCHEDULER -- requirements
Module: voice_scheduler

Interface
REQ-001 SHALL have parameter DUR_W, default 6, duration counter width in beats.
REQ-002 SHALL have parameter NOTE_W, default 6, note code width.
REQ-003 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-005 SHALL have port play  input  1  level; low freezes all duration counting.
REQ-006 SHALL have port beat  input  1  one-cycle 48 Hz beat pulse.
REQ-007 SHALL have port load_new_note  input  1  one-cycle request to place note_in/duration_in on a voice.
REQ-008 SHALL have ports note_in  input  NOTE_W and duration_in  input  DUR_W, the request payload, sampled with load_new_note.
REQ-009 SHALL have port activate  input  1  one-cycle pulse: chord fully loaded, start counting.
REQ-010 SHALL have port voice_load  output  3  one-hot one-cycle load strobe to voice 0..2.
REQ-011 SHALL have ports voice_note  output  NOTE_W and voice_duration  output  DUR_W, the payload valid with voice_load.
REQ-012 SHALL have port voice_active  output  3  level; bit i high while voice i counter nonzero.
REQ-013 SHALL have ports activate_done, note_done, dropped  output  1 each  one-cycle pulses.

Function
REQ-014 SHALL implement states IDLE, LOAD, COUNT; IDLE->LOAD on accepted load, LOAD->COUNT on activate, COUNT->IDLE when all counters reach 0.
REQ-015 SHALL assign an accepted request to the lowest-index voice whose counter is 0.
REQ-016 SHALL register voice_load/voice_note/voice_duration exactly 1 cycle after load_new_note.
REQ-017 SHALL ignore (no strobe, no drop) any request with duration_in = 0.
REQ-018 SHALL pulse activate_done 1 cycle after activate; activate in IDLE with no voice active SHALL also pulse note_done that same cycle and stay IDLE.
REQ-019 SHALL, in COUNT with play high, decrement every nonzero counter by 1 on each beat; counters SHALL never wrap below 0.
REQ-020 SHALL ignore beat in IDLE, LOAD, or while play low.
REQ-021 SHALL pulse note_done for 1 cycle in the cycle after the last counter reaches 0, entering IDLE simultaneously.
REQ-022 SHALL accept loads in COUNT into a free voice; a load coinciding with beat SHALL load the full duration_in, undecremented, while other voices decrement.
REQ-023 SHALL treat a voice reaching 0 and a load in the same cycle as free, so that voice is eligible.
REQ-024 SHALL give a second load_new_note before the previous strobe issues the next free voice (back-to-back, no loss).

Reset
REQ-025 SHALL, on reset low, asynchronously clear all counters, state to IDLE, and every output to 0.
REQ-026 SHALL, on reset mid-COUNT, emit no note_done; the first cycle after release SHALL be IDLE.

Configuration
REQ-027 With VOICE_STEAL_EN defined, a request with all voices busy SHALL overwrite the voice with smallest remaining count (lowest index on tie), strobe it, and not pulse dropped.
REQ-028 Without VOICE_STEAL_EN, a request with all voices busy SHALL be discarded, with dropped pulsing 1 cycle later and no voice_load.

Verification
REQ-029 Loads (note 10,dur 2),(20,3),(30,1), then activate -> voice_load 001,010,100; activate_done; note_done 1 cycle after the 3rd beat.
REQ-030 In COUNT with voice_active=111, play low for 5 beats -> counters unchanged, no note_done.
REQ-031 Fourth load (40,4) with voices at 2,3,1: steal build -> voice_load=100, voice_duration=4; non-steal build -> dropped pulse, voice_load=000.
REQ-032 Load (5,0) -> no voice_load, no dropped; activate -> activate_done and note_done in the same cycle.
REQ-033 Voice 0 at 1, beat plus load (7,3) same cycle -> voice_load=001, voice_duration=3, voice_active[0] remains 1.
REQ-034 reset low mid-COUNT with counters 2,2,2 -> all outputs 0 immediately, no note_done after release.
